// File: rtl/lsu_store_issue.sv
// Store issue stage: lane-aligns store data, builds byte enables and runs a
// single-outstanding req/ack write to data memory, reporting done or error.
module lsu_store_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_nop,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic [1:0]  size,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        store_done,
  output logic        store_err,
  output logic [1:0]  err_cause
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_SIZE     = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } cause_e;

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        misaligned;
  logic        bad_size;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    lane_be    = 4'b0000;
    lane_wdata = 32'h0;
    misaligned = 1'b0;
    bad_size   = 1'b0;
    unique case (size)
      2'b00: begin
        lane_be    = 4'b0001 << addr[1:0];
        lane_wdata = {4{data_in[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << addr[1:0];
        lane_wdata = {2{data_in[15:0]}};
        misaligned = addr[0];
      end
      2'b10: begin
        lane_be    = 4'b1111;
        lane_wdata = data_in;
        misaligned = (addr[1:0] != 2'b00);
      end
      default: bad_size = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && is_store && !is_nop) begin
          state_d = S_RESP;
          cnt_d   = '0;
          // Invalid size outranks misalignment.
          if (bad_size) begin
            cause_d = CAUSE_SIZE;
          end else if (misaligned) begin
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = S_REQ;
            cause_d = CAUSE_NONE;
            addr_d  = {addr[31:2], 2'b00};
            wdata_d = lane_wdata;
            be_d    = lane_be;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_RESP;
          cause_d = CAUSE_NONE;
          cnt_d   = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          // Ack on the limit cycle is handled above, so it beats the timeout.
          if (cnt_q == CNT_LAST) begin
            state_d = S_RESP;
            cause_d = CAUSE_TIMEOUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cause_d = CAUSE_NONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Memory-side buses read as zero whenever no request is active.
  always_comb begin
    in_ready   = (state_q == S_IDLE);
    mem_req    = (state_q == S_REQ);
    mem_we     = mem_req;
    mem_addr   = mem_req ? addr_q  : 32'h0;
    mem_wdata  = mem_req ? wdata_q : 32'h0;
    mem_be     = mem_req ? be_q    : 4'b0000;
    store_done = (state_q == S_RESP) && (cause_q == CAUSE_NONE);
    store_err  = (state_q == S_RESP) && (cause_q != CAUSE_NONE);
    err_cause  = store_err ? cause_q : CAUSE_NONE;
  end

endmodule

// File: tb/tb_lsu_store_issue.sv
// Directed bench for lsu_store_issue: lane/enable formation, ack latency,
// error causes, timeout (second instance with a 4-cycle limit) and async reset.
module tb_lsu_store_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, t_valid;
  logic        is_nop, is_store;
  logic [31:0] addr, data_in;
  logic [1:0]  size;
  logic        mem_ack, t_ack;

  logic        in_ready, mem_req, mem_we, store_done, store_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  err_cause;

  logic        t_ready, t_req, t_we, t_done, t_err;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;
  logic [1:0]  t_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_store_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_nop(is_nop), .is_store(is_store), .addr(addr), .data_in(data_in),
    .size(size), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .store_done(store_done), .store_err(store_err), .err_cause(err_cause)
  );

  lsu_store_issue #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_valid), .in_ready(t_ready),
    .is_nop(is_nop), .is_store(is_store), .addr(addr), .data_in(data_in),
    .size(size), .mem_req(t_req), .mem_we(t_we), .mem_addr(t_addr),
    .mem_wdata(t_wdata), .mem_be(t_be), .mem_ack(t_ack),
    .store_done(t_done), .store_err(t_err), .err_cause(t_cause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic nop, input logic st, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    is_nop = nop; is_store = st; size = sz; addr = a; data_in = d;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; t_valid = 1'b0; mem_ack = 1'b0; t_ack = 1'b0;
    offer(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_pulses", {30'd0, store_done, store_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Ack arriving in IDLE is ignored.
    mem_ack = 1'b1;
    tick();
    check("idle_ack_ignored", {29'd0, mem_req, store_done, store_err}, 32'd0);
    mem_ack = 1'b0;

    // SB, ack on first REQ cycle.
    offer(1'b0, 1'b1, 2'b00, 32'h0000_1003, 32'hDEAD_BEEF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sb_req", {30'd0, mem_req, mem_we}, 32'd3);
    check("sb_ready", 32'(in_ready), 32'd0);
    check("sb_addr", mem_addr, 32'h0000_1000);
    check("sb_be", 32'(mem_be), 32'h8);
    check("sb_wdata", mem_wdata, 32'hEFEF_EFEF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_done", {30'd0, store_done, store_err}, 32'd2);
    check("sb_req_drop", {27'd0, mem_req, mem_be}, 32'd0);
    tick();
    check("sb_idle", {29'd0, in_ready, store_done, store_err}, 32'd4);

    // SH, ack after 5 waiting cycles: bus held for 6 REQ cycles.
    offer(1'b0, 1'b1, 2'b01, 32'h0000_2002, 32'h0000_CAFE);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("sh_hold_req", {30'd0, mem_req, store_done}, 32'd2);
      check("sh_hold_be", 32'(mem_be), 32'hC);
      check("sh_hold_wdata", mem_wdata, 32'hCAFE_CAFE);
      check("sh_hold_addr", mem_addr, 32'h0000_2000);
      if (i == 5) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    check("sh_done", {29'd0, mem_req, store_done, store_err}, 32'd2);
    tick();
    check("sh_single_done", {30'd0, store_done, in_ready}, 32'd1);

    // Misaligned SW: error one cycle after accept, no request.
    offer(1'b0, 1'b1, 2'b10, 32'h0000_3001, 32'h1111_2222);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("misal_err", {29'd0, mem_req, store_done, store_err}, 32'd1);
    check("misal_cause", 32'(err_cause), 32'd1);
    tick();
    check("misal_clear", {28'd0, err_cause, store_err, in_ready}, 32'd1);

    // Invalid size outranks misalignment.
    offer(1'b0, 1'b1, 2'b11, 32'h0000_3001, 32'h1111_2222);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("size_err", {29'd0, mem_req, store_done, store_err}, 32'd1);
    check("size_cause", 32'(err_cause), 32'd2);
    tick();

    // Timeout instance: no ack -> 4 request cycles, then cause 11.
    offer(1'b0, 1'b1, 2'b10, 32'h0000_4000, 32'h1234_5678);
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_req_high", {30'd0, t_req, t_err}, 32'd2);
      check("to_wdata", t_wdata, 32'h1234_5678);
      tick();
    end
    check("to_req_low", 32'(t_req), 32'd0);
    check("to_err", {29'd0, t_done, t_err, 1'b0}, 32'd2);
    check("to_cause", 32'(t_cause), 32'd3);
    tick();
    check("to_idle", {30'd0, t_ready, t_err}, 32'd2);

    // Ack on the 4th (limit) cycle wins over the timeout.
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tack_req_high", 32'(t_req), 32'd1);
      if (i == 3) t_ack = 1'b1;
      tick();
    end
    t_ack = 1'b0;
    check("tack_done", {28'd0, t_cause, t_done, t_err}, 32'd2);
    tick();

    // Back-to-back: load, NOP, then SW offered consecutively.
    offer(1'b0, 1'b0, 2'b10, 32'h0000_5000, 32'hAAAA_5555);
    in_valid = 1'b1;
    tick();
    check("load_silent", {28'd0, in_ready, mem_req, store_done, store_err}, 32'd8);
    offer(1'b1, 1'b1, 2'b10, 32'h0000_5000, 32'hAAAA_5555);
    tick();
    check("nop_silent", {28'd0, in_ready, mem_req, store_done, store_err}, 32'd8);
    offer(1'b0, 1'b1, 2'b10, 32'h0000_5000, 32'hAAAA_5555);
    tick();
    check("b2b_req", {30'd0, in_ready, mem_req}, 32'd1);
    check("b2b_addr", mem_addr, 32'h0000_5000);
    check("b2b_be", 32'(mem_be), 32'hF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("b2b_resp", {29'd0, in_ready, store_done, store_err}, 32'd2);
    in_valid = 1'b0;
    tick();
    check("b2b_idle", {30'd0, in_ready, mem_req}, 32'd2);

    // Async reset while in REQ.
    offer(1'b0, 1'b1, 2'b10, 32'h0000_6000, 32'h0BAD_F00D);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rstmid_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_drop", {30'd0, mem_req, in_ready}, 32'd1);
    check("rstmid_bus", mem_wdata, 32'h0);
    tick();
    check("rstmid_held", {30'd0, store_done, store_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rstmid_release", {29'd0, in_ready, store_done, store_err}, 32'd4);
    tick();
    check("rstmid_no_pulse", {29'd0, mem_req, store_done, store_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
